lcd_timing_gen: RTL and testbench

// - Raster timing generator for the parallel RGB TFT panel on the Tang Nano 9K (GW1NR-9C).
// - Sits upstream of the pixel/draw logic.
// - Produces HSYNC/VSYNC/DEN and the pixel coordinates XPOS/YPOS, all registered on PIXEL_CLK.
// - Also produces line/frame strobes and a frame counter.
// - Draw logic animates from the frame counter and FRAME_START, never by clocking on a sync edge.

---
 rtl/lcd_timing_gen_pkg.sv | 48 ++++
 rtl/lcd_timing_gen_if.sv | 26 ++
 rtl/lcd_timing_gen_axis_counter.sv | 54 +++++
 rtl/lcd_timing_gen.sv | 101 ++++++++++
 tb/tb_lcd_timing_gen.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_gen_pkg.sv
// Shared constants and types for the TFT raster timing generator: panel timing
// sets, default sync polarities and the registered output bundle.
package lcd_timing_gen_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned FCNT_W    = 8;
  localparam int unsigned MAX_TOTAL = 2048;

  // 480x272 panel (Tang Nano 9K default)
  localparam int unsigned LCD_480_272_H_ACTIVE = 480;
  localparam int unsigned LCD_480_272_H_FP     = 2;
  localparam int unsigned LCD_480_272_H_SYNC   = 41;
  localparam int unsigned LCD_480_272_H_BP     = 2;
  localparam int unsigned LCD_480_272_V_ACTIVE = 272;
  localparam int unsigned LCD_480_272_V_FP     = 2;
  localparam int unsigned LCD_480_272_V_SYNC   = 10;
  localparam int unsigned LCD_480_272_V_BP     = 2;

  // 800x480 panel
  localparam int unsigned LCD_800_480_H_ACTIVE = 800;
  localparam int unsigned LCD_800_480_H_FP     = 40;
  localparam int unsigned LCD_800_480_H_SYNC   = 48;
  localparam int unsigned LCD_800_480_H_BP     = 40;
  localparam int unsigned LCD_800_480_V_ACTIVE = 480;
  localparam int unsigned LCD_800_480_V_FP     = 13;
  localparam int unsigned LCD_800_480_V_SYNC   = 3;
  localparam int unsigned LCD_800_480_V_BP     = 29;

  localparam logic HS_POL_DEFAULT = 1'b0;
  localparam logic VS_POL_DEFAULT = 1'b0;

  typedef struct packed {
    logic               den;
    logic               hsync;
    logic               vsync;
    logic               line_start;
    logic               frame_start;
    logic [COORD_W-1:0] xpos;
    logic [COORD_W-1:0] ypos;
    logic [FCNT_W-1:0]  frame_cnt;
  } raster_out_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Panel-side signal bundle of the raster timing generator; master is the
// generator, slave is the draw logic consuming the raster.
interface lcd_timing_gen_if;
  import lcd_timing_gen_pkg::*;

  logic               enable;
  logic               hsync;
  logic               vsync;
  logic               den;
  logic [COORD_W-1:0] xpos;
  logic [COORD_W-1:0] ypos;
  logic               line_start;
  logic               frame_start;
  logic [FCNT_W-1:0]  frame_cnt;

  modport master (
    input  enable,
    output hsync, vsync, den, xpos, ypos, line_start, frame_start, frame_cnt
  );

  modport slave (
    output enable,
    input  hsync, vsync, den, xpos, ypos, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/lcd_timing_gen_axis_counter.sv
// One raster axis: counts ACTIVE, FP, SYNC, BP positions in that order and
// decodes the active and sync windows from the current count.
module lcd_axis_counter
  import lcd_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = 480,
  parameter int unsigned FP     = 2,
  parameter int unsigned SYNC   = 41,
  parameter int unsigned BP     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               step_i,
  output logic [COORD_W-1:0] count_o,
  output logic               wrap_o,
  output logic               active_o,
  output logic               sync_active_o
);

  localparam int unsigned        TOTAL     = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [COORD_W-1:0] LAST_C    = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACTIVE_C  = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_LO_C = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] SYNC_HI_C = COORD_W'(ACTIVE + FP + SYNC);

  logic [COORD_W-1:0] count_q, count_d;
  logic               at_last_s;

  assign at_last_s     = (count_q == LAST_C);
  assign wrap_o        = step_i && at_last_s;
  assign count_o       = count_q;
  assign active_o      = (count_q < ACTIVE_C);
  assign sync_active_o = (count_q >= SYNC_LO_C) && (count_q < SYNC_HI_C);

  // next count: advance on step, wrapping after the last back-porch position
  always_comb begin
    count_d = count_q;
    if (step_i) begin
      count_d = at_last_s ? {COORD_W{1'b0}} : count_q + {{(COORD_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {COORD_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a parallel RGB TFT panel. Every output is a flop
// decoded from the counter position about to be shown, so outputs never skew.
module lcd_timing_gen
  import lcd_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD_480_272_H_ACTIVE,
  parameter int unsigned H_FP     = LCD_480_272_H_FP,
  parameter int unsigned H_SYNC   = LCD_480_272_H_SYNC,
  parameter int unsigned H_BP     = LCD_480_272_H_BP,
  parameter int unsigned V_ACTIVE = LCD_480_272_V_ACTIVE,
  parameter int unsigned V_FP     = LCD_480_272_V_FP,
  parameter int unsigned V_SYNC   = LCD_480_272_V_SYNC,
  parameter int unsigned V_BP     = LCD_480_272_V_BP,
  parameter logic        HS_POL   = HS_POL_DEFAULT,
  parameter logic        VS_POL   = VS_POL_DEFAULT
) (
  input  logic              pixel_clk_i,
  input  logic              rst_i,
  lcd_timing_gen_if.master  lcd
);

  localparam raster_out_t OUT_RESET = '{
    den:         1'b0,
    hsync:       ~HS_POL,
    vsync:       ~VS_POL,
    line_start:  1'b0,
    frame_start: 1'b0,
    xpos:        {COORD_W{1'b0}},
    ypos:        {COORD_W{1'b0}},
    frame_cnt:   {FCNT_W{1'b0}}
  };

  logic [COORD_W-1:0] h_cnt_s, v_cnt_s;
  logic               h_wrap_s, v_wrap_s;
  logic               h_act_s, v_act_s;
  logic               h_sync_s, v_sync_s;
  raster_out_t        out_q, out_d;
  logic               origin_q, origin_d;

  lcd_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .clk_i         (pixel_clk_i),
    .rst_i         (rst_i),
    .step_i        (lcd.enable),
    .count_o       (h_cnt_s),
    .wrap_o        (h_wrap_s),
    .active_o      (h_act_s),
    .sync_active_o (h_sync_s)
  );

  lcd_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .clk_i         (pixel_clk_i),
    .rst_i         (rst_i),
    .step_i        (h_wrap_s),
    .count_o       (v_cnt_s),
    .wrap_o        (v_wrap_s),
    .active_o      (v_act_s),
    .sync_active_o (v_sync_s)
  );

  // decode the position about to be shown; disabled cycles blank everything but frame_cnt
  // origin_q marks counters sitting at (0,0): set by reset and by the vertical wrap
  always_comb begin
    out_d           = OUT_RESET;
    out_d.frame_cnt = out_q.frame_cnt;
    origin_d        = origin_q;
    if (lcd.enable) begin
      out_d.den         = h_act_s && v_act_s;
      out_d.hsync       = h_sync_s ? HS_POL : ~HS_POL;
      out_d.vsync       = v_sync_s ? VS_POL : ~VS_POL;
      out_d.xpos        = (h_act_s && v_act_s) ? h_cnt_s : {COORD_W{1'b0}};
      out_d.ypos        = (h_act_s && v_act_s) ? v_cnt_s : {COORD_W{1'b0}};
      out_d.line_start  = (h_cnt_s == {COORD_W{1'b0}}) && v_act_s;
      out_d.frame_start = origin_q;
      out_d.frame_cnt   = out_q.frame_cnt + {{(FCNT_W-1){1'b0}}, origin_q};
      origin_d          = v_wrap_s;
    end else begin
      origin_d = origin_q;
    end
  end

  // output and origin registers
  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= OUT_RESET;
      origin_q <= 1'b1;
    end else begin
      out_q    <= out_d;
      origin_q <= origin_d;
    end
  end

  assign lcd.den         = out_q.den;
  assign lcd.hsync       = out_q.hsync;
  assign lcd.vsync       = out_q.vsync;
  assign lcd.xpos        = out_q.xpos;
  assign lcd.ypos        = out_q.ypos;
  assign lcd.line_start  = out_q.line_start;
  assign lcd.frame_start = out_q.frame_start;
  assign lcd.frame_cnt   = out_q.frame_cnt;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench: default 480x272 geometry for line, freeze and reset behaviour,
// plus a tiny geometry run over 257 frames for vertical timing and counter wrap.
module tb_lcd_timing_gen;

  logic clk;
  logic rst_d;
  logic rst_s;
  int   checks;
  int   errors;

  lcd_timing_gen_if if_d ();
  lcd_timing_gen_if if_s ();

  lcd_timing_gen u_dut_default (
    .pixel_clk_i (clk),
    .rst_i       (rst_d),
    .lcd         (if_d)
  );

  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_small (
    .pixel_clk_i (clk),
    .rst_i       (rst_s),
    .lcd         (if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {den, hsync, vsync, line_start, frame_start, xpos, ypos, frame_cnt}
  function automatic logic [34:0] snap_d();
    return {if_d.den, if_d.hsync, if_d.vsync, if_d.line_start, if_d.frame_start,
            if_d.xpos, if_d.ypos, if_d.frame_cnt};
  endfunction

  function automatic logic [34:0] snap_s();
    return {if_s.den, if_s.hsync, if_s.vsync, if_s.line_start, if_s.frame_start,
            if_s.xpos, if_s.ypos, if_s.frame_cnt};
  endfunction

  task automatic test_reset();
    logic [34:0] exp_v;
    rst_d = 1'b1;
    if_d.enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0};
    checks++;
    if (snap_d() !== exp_v) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", snap_d(), exp_v);
    end
    rst_d = 1'b0;
    @(posedge clk);
    #1;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 8'd1};
    checks++;
    if (snap_d() !== exp_v) begin
      errors++;
      $display("FAIL first_pixel got %h expected %h", snap_d(), exp_v);
    end
  endtask

  task automatic test_line();
    int den_cnt = 0;
    int hs_cnt  = 0;
    int hs_first = -1;
    logic [13:0] exp_v;
    logic [13:0] obs_v;
    for (int i = 0; i < 525; i++) begin
      exp_v = {(i < 480), !(i >= 482 && i < 523), (i == 0), (i < 480) ? 11'(i) : 11'd0};
      obs_v = {if_d.den, if_d.hsync, if_d.line_start, if_d.xpos};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL line0_pixel %0d got %h expected %h", i, obs_v, exp_v);
      end
      if (if_d.den === 1'b1) den_cnt++;
      if (if_d.hsync === 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_cnt++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (den_cnt != 480) begin
      errors++;
      $display("FAIL den_count got %0d expected 480", den_cnt);
    end
    checks++;
    if (hs_first != 482 || hs_cnt != 41) begin
      errors++;
      $display("FAIL hsync_window got start %0d len %0d expected start 482 len 41", hs_first, hs_cnt);
    end
    checks++;
    if ({if_d.den, if_d.line_start, if_d.frame_start, if_d.xpos, if_d.ypos, if_d.frame_cnt} !==
        {1'b1, 1'b1, 1'b0, 11'd0, 11'd1, 8'd1}) begin
      errors++;
      $display("FAIL line1_start got x=%0d y=%0d ls=%b fs=%b", if_d.xpos, if_d.ypos,
               if_d.line_start, if_d.frame_start);
    end
  endtask

  task automatic test_enable_freeze();
    logic [34:0] exp_v;
    repeat (49 * 525 + 99) @(posedge clk);
    #1;
    checks++;
    if (if_d.xpos !== 11'd99 || if_d.ypos !== 11'd50) begin
      errors++;
      $display("FAIL pre_freeze_pos got %0d,%0d expected 99,50", if_d.xpos, if_d.ypos);
    end
    if_d.enable = 1'b0;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 8'd1};
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (snap_d() !== exp_v) begin
        errors++;
        $display("FAIL frozen_cycle %0d got %h expected %h", i, snap_d(), exp_v);
      end
    end
    if_d.enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({if_d.den, if_d.xpos, if_d.ypos} !== {1'b1, 11'(100 + i), 11'd50}) begin
        errors++;
        $display("FAIL resume %0d got x=%0d y=%0d den=%b expected x=%0d y=50", i,
                 if_d.xpos, if_d.ypos, if_d.den, 100 + i);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [34:0] exp_v;
    repeat (2 * 525 + 199) @(posedge clk);
    #1;
    checks++;
    if (if_d.xpos !== 11'd300 || if_d.ypos !== 11'd52) begin
      errors++;
      $display("FAIL pre_reset_pos got %0d,%0d expected 300,52", if_d.xpos, if_d.ypos);
    end
    #3;
    rst_d = 1'b1;
    #1;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 8'd0};
    checks++;
    if (snap_d() !== exp_v) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", snap_d(), exp_v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (snap_d() !== exp_v) begin
      errors++;
      $display("FAIL held_reset got %h expected %h", snap_d(), exp_v);
    end
    rst_d = 1'b0;
    @(posedge clk);
    #1;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 8'd1};
    checks++;
    if (snap_d() !== exp_v) begin
      errors++;
      $display("FAIL restart_origin got %h expected %h", snap_d(), exp_v);
    end
    @(posedge clk);
    #1;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1, 11'd0, 8'd1};
    checks++;
    if (snap_d() !== exp_v) begin
      errors++;
      $display("FAIL restart_next got %h expected %h", snap_d(), exp_v);
    end
  endtask

  // tiny geometry: 7 clocks per line, 5 lines per frame
  task automatic test_small_frames();
    logic [34:0] exp_v;
    logic [7:0]  fc_exp = 8'd0;
    int          fs_cnt = 0;
    int          h;
    int          v;
    logic        den_e;
    rst_s = 1'b1;
    if_s.enable = 1'b0;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    if_s.enable = 1'b1;
    for (int f = 0; f < 257; f++) begin
      for (int c = 0; c < 35; c++) begin
        @(posedge clk);
        #1;
        h = c % 7;
        v = c / 7;
        den_e = (h < 4) && (v < 2);
        if (c == 0) fc_exp = fc_exp + 8'd1;
        exp_v = {den_e, (h != 5), (v != 3), (h == 0 && v < 2), (c == 0),
                 den_e ? 11'(h) : 11'd0, den_e ? 11'(v) : 11'd0, fc_exp};
        checks++;
        if (snap_s() !== exp_v) begin
          errors++;
          $display("FAIL small_frame %0d cycle %0d got %h expected %h", f, c, snap_s(), exp_v);
        end
        if (if_s.frame_start === 1'b1) fs_cnt++;
      end
    end
    checks++;
    if (fs_cnt != 257 || if_s.frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL small_wrap got starts %0d cnt %0d expected starts 257 cnt 1", fs_cnt, if_s.frame_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_d = 1'b1;
    rst_s = 1'b1;
    if_d.enable = 1'b0;
    if_s.enable = 1'b0;
    test_reset();
    test_line();
    test_enable_freeze();
    test_reset_mid_frame();
    test_small_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
